// File: rtl/stoch_decode_mat_if.sv
// Bus between a stochastic matrix source/host and the matrix stochastic-to-binary decoder.
// The master drives the window request, sample strobe and bits; the slave returns counts and status.
interface stoch_decode_mat_if #(
   parameter int unsigned NUM_ROWS    = 2,
   parameter int unsigned NUM_COLS    = 2,
   parameter int unsigned WINDOW_BITS = 8
);
   logic                                              start;
   logic                                              en;
   logic [NUM_ROWS-1:0][NUM_COLS-1:0]                 a;
   logic [NUM_ROWS-1:0][NUM_COLS-1:0][WINDOW_BITS:0]  y;
   logic                                              busy;
   logic                                              done;

   modport master (output start, en, a, input y, busy, done);
   modport slave  (input start, en, a, output y, busy, done);
endinterface

// File: rtl/stoch_decode_mat.sv
// Matrix stochastic-to-binary decoder: counts ones per element over 2**WINDOW_BITS
// enabled samples, then latches every element count into y at once.
module stoch_decode_mat #(
   parameter int unsigned NUM_ROWS    = 2,
   parameter int unsigned NUM_COLS    = 2,
   parameter int unsigned WINDOW_BITS = 8
) (
   input  logic              clk,
   input  logic              rst,
   stoch_decode_mat_if.slave bus
);
   localparam int unsigned CW = WINDOW_BITS + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DONE} state_t;

   state_t                  state;
   logic [WINDOW_BITS-1:0]  cnt;
   logic                    busy;
   logic                    done;
   logic                    clr_c;
   logic                    add_c;
   logic                    last_c;
   logic [NUM_ROWS-1:0][NUM_COLS-1:0][CW-1:0] y_all;

   // Shared element controls: START only opens a window outside ACCUM.
   assign clr_c  = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
   assign add_c  = (state == ST_ACCUM) && bus.en;
   assign last_c = add_c && (cnt == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (clr_c) begin
                  state <= ST_ACCUM;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            ST_ACCUM: begin
               // Counter wraps to zero on the final sample.
               if (add_c) begin
                  cnt <= cnt + WINDOW_BITS'(1);
                  if (last_c) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (clr_c) begin
                  state <= ST_ACCUM;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.y    = y_all;

   for (genvar r = 0; r < int'(NUM_ROWS); r++) begin : g_row
      for (genvar c = 0; c < int'(NUM_COLS); c++) begin : g_col
         logic [CW-1:0] acc;
         logic [CW-1:0] y_q;
         logic [CW-1:0] sum_c;

         // Final sample is folded into the latched result on the same edge.
         assign sum_c = acc + CW'(bus.a[r][c]);

         always_ff @(posedge clk) begin
            if (rst) begin
               acc <= '0;
               y_q <= '0;
            end else begin
               if (clr_c) begin
                  acc <= '0;
               end else if (add_c) begin
                  acc <= sum_c;
               end
               if (last_c) begin
                  y_q <= sum_c;
               end
            end
         end

         assign y_all[r][c] = y_q;
      end
   end
endmodule

// File: tb/tb_stoch_decode_mat.sv
// Scoreboard bench for stoch_decode_mat: a 2x2 W=4 instance and a 3x2 W=8 instance.
module tb_stoch_decode_mat;
   typedef logic [1:0][1:0][4:0] y4_t;
   typedef logic [2:0][1:0][8:0] y8_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   y4_t  q4[$];
   y8_t  q8[$];
   y4_t  last4 = '0;
   y8_t  last8 = '0;

   always #5 clk = ~clk;

   stoch_decode_mat_if #(.NUM_ROWS(2), .NUM_COLS(2), .WINDOW_BITS(4)) if4 ();
   stoch_decode_mat_if #(.NUM_ROWS(3), .NUM_COLS(2), .WINDOW_BITS(8)) if8 ();

   stoch_decode_mat #(.NUM_ROWS(2), .NUM_COLS(2), .WINDOW_BITS(4)) dut4 (
      .clk(clk), .rst(rst), .bus(if4.slave));
   stoch_decode_mat #(.NUM_ROWS(3), .NUM_COLS(2), .WINDOW_BITS(8)) dut8 (
      .clk(clk), .rst(rst), .bus(if8.slave));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard pop on every DONE pulse.
   always @(negedge clk) begin
      if (if4.done === 1'b1) begin
         check("busy_and_done4", 64'(if4.busy), 64'd0);
         if (q4.size() == 0) check("unexpected_done4", 64'd1, 64'd0);
         else check("y4", 64'(if4.y), 64'(q4.pop_front()));
      end
      if (if8.done === 1'b1) begin
         check("busy_and_done8", 64'(if8.busy), 64'd0);
         if (q8.size() == 0) check("unexpected_done8", 64'd1, 64'd0);
         else check("y8", 64'(if8.y), 64'(q8.pop_front()));
      end
   end

   function automatic logic [1:0][1:0] gen4(input int pat, input int s);
      logic [1:0][1:0] v;
      v = 4'($urandom);
      if (pat == 0) begin
         v = '1;
      end else if (pat == 1) begin
         v[0][0] = (s % 4 == 0);
         v[1][1] = 1'b0;
      end
      return v;
   endfunction

   // One W=4 window; start_at re-pulses START mid-window, abort_at resets mid-window.
   task automatic window4(input int pat, input bit toggle, input int start_at, input int abort_at);
      y4_t exp;
      int  s;
      int  cyc;
      exp = '0; s = 0; cyc = 0;
      if4.start = 1'b1; if4.en = 1'b1; if4.a = '1;
      @(posedge clk); #1;
      if4.start = 1'b0;
      while (s < 16) begin
         cyc++;
         check("busy4", 64'(if4.busy), 64'd1);
         check("yhold4", 64'(if4.y), 64'(last4));
         if (s == abort_at) begin
            rst = 1'b1; if4.en = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0; if4.en = 1'b0;
            check("abort_busy4", 64'(if4.busy), 64'd0);
            check("abort_y4", 64'(if4.y), 64'd0);
            check("abort_done4", 64'(if4.done), 64'd0);
            last4 = '0;
            return;
         end
         if4.en    = toggle ? cyc[0] : 1'b1;
         if4.a     = gen4(pat, s);
         if4.start = (s == start_at);
         if (if4.en) begin
            for (int r = 0; r < 2; r++)
               for (int c = 0; c < 2; c++)
                  exp[r][c] = exp[r][c] + 5'(if4.a[r][c]);
            s++;
         end
         if (s == 16) q4.push_back(exp);
         @(posedge clk); #1;
      end
      if4.start = 1'b0; if4.en = 1'b0;
      check("done4", 64'(if4.done), 64'd1);
      check("busy_in_done4", 64'(if4.busy), 64'd0);
      last4 = exp;
   endtask

   task automatic idle4();
      if4.start = 1'b0; if4.en = 1'b0;
      @(posedge clk); #1;
      check("idle_busy4", 64'(if4.busy), 64'd0);
      check("idle_done4", 64'(if4.done), 64'd0);
      check("idle_y4", 64'(if4.y), 64'(last4));
   endtask

   // One W=8 window with Bernoulli(p4/4) bits and a random sample strobe.
   task automatic window8(input int p4);
      y8_t exp;
      int  s;
      exp = '0; s = 0;
      if8.start = 1'b1; if8.en = 1'b0;
      @(posedge clk); #1;
      if8.start = 1'b0;
      while (s < 256) begin
         check("busy8", 64'(if8.busy), 64'd1);
         check("yhold8", 64'(if8.y), 64'(last8));
         if8.en = ($urandom_range(3) != 0);
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 2; c++)
               if8.a[r][c] = (int'($urandom_range(3)) < p4);
         if (if8.en) begin
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 2; c++)
                  exp[r][c] = exp[r][c] + 9'(if8.a[r][c]);
            s++;
         end
         if (s == 256) q8.push_back(exp);
         @(posedge clk); #1;
      end
      if8.en = 1'b0;
      check("done8", 64'(if8.done), 64'd1);
      last8 = exp;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      if4.start = 1'b0; if4.en = 1'b0; if4.a = '0;
      if8.start = 1'b0; if8.en = 1'b0; if8.a = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_y4", 64'(if4.y), 64'd0);
      check("rst_busy4", 64'(if4.busy), 64'd0);
      check("rst_done4", 64'(if4.done), 64'd0);
      check("rst_y8", 64'(if8.y), 64'd0);

      window4(0, 1'b0, -1, -1);
      check("all_ones_y11", 64'(if4.y[1][1]), 64'd16);
      idle4();

      window4(1, 1'b0, -1, -1);
      check("quarter_y00", 64'(if4.y[0][0]), 64'd4);
      check("zero_y11", 64'(if4.y[1][1]), 64'd0);
      idle4();

      window4(0, 1'b1, -1, -1);
      check("toggle_y00", 64'(if4.y[0][0]), 64'd16);
      idle4();

      window4(2, 1'b0, 7, -1);
      window4(1, 1'b0, -1, -1);
      idle4();

      window4(0, 1'b0, -1, 10);
      idle4();
      window4(2, 1'b0, -1, -1);
      idle4();

      foreach (q4[i]) check("q4_leftover", 64'd1, 64'd0);

      window8(0);
      check("p0_y00", 64'(if8.y[0][0]), 64'd0);
      check("p0_y21", 64'(if8.y[2][1]), 64'd0);
      @(posedge clk); #1;
      window8(1);
      window8(2);
      @(posedge clk); #1;
      window8(4);
      check("p1_y00", 64'(if8.y[0][0]), 64'd256);
      check("p1_y21", 64'(if8.y[2][1]), 64'd256);
      @(posedge clk); #1;
      check("idle_busy8", 64'(if8.busy), 64'd0);

      repeat (3) @(posedge clk);
      #1;
      check("q4_empty", 64'(q4.size()), 64'd0);
      check("q8_empty", 64'(q8.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
